// File: rtl/bcd_time_counter.sv
// HH:MM:SS timekeeping core with packed BCD digits, RUN/SET modes and optional 12-hour display.
// Handshake: tick_1hz and set_inc are single-cycle strobes sampled on every rising edge; no back-pressure.
module bcd_time_counter #(
  parameter bit HOURS_24 = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       set_en,
  input  logic [1:0] set_sel,
  input  logic       set_inc,
  output logic [1:0] hr_tens,
  output logic [3:0] hr_ones,
  output logic [2:0] min_tens,
  output logic [3:0] min_ones,
  output logic [2:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       pm,
  output logic       day_wrap,
  output logic       in_set
);

  typedef enum logic {RUN = 1'b0, SET = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [6:0] sec_q, sec_d, min_q, min_d;
  logic [5:0] hr_q, hr_d;
  logic       pm_q, pm_d, wrap_q, wrap_d;
  logic [7:0] sec_inc, min_inc, hr_inc;

  // Returns {carry, tens, ones}; an illegal pair restarts at 00 without carrying.
  function automatic logic [7:0] inc_60(input logic [6:0] v);
    logic [2:0] t;
    logic [3:0] o;
    t = v[6:4];
    o = v[3:0];
    if (o > 4'd9 || t > 3'd5) return 8'd0;
    if (o != 4'd9) return {1'b0, t, o + 4'd1};
    if (t == 3'd5) return {1'b1, 7'd0};
    return {1'b0, t + 3'd1, 4'd0};
  endfunction

  // Returns {day_wrap, pm, tens, ones} for one hour step in the configured mode.
  function automatic logic [7:0] inc_hr(input logic [5:0] v, input logic p);
    logic [1:0] t;
    logic [3:0] o;
    t = v[5:4];
    o = v[3:0];
    if (HOURS_24) begin
      if (o > 4'd9 || t > 2'd2 || (t == 2'd2 && o > 4'd3)) return 8'd0;
      if (t == 2'd2 && o == 4'd3) return {1'b1, 1'b0, 6'h00};
    end else begin
      if (o > 4'd9 || t > 2'd1 || (t == 2'd0 && o == 4'd0) || (t == 2'd1 && o > 4'd2))
        return {1'b0, p, 6'h12};
      if (t == 2'd1 && o == 4'd2) return {1'b0, p, 6'h01};
      // 11 -> 12 flips AM/PM; leaving PM is the start of a new day
      if (t == 2'd1 && o == 4'd1) return {p, ~p, 6'h12};
    end
    if (o != 4'd9) return {1'b0, p, t, o + 4'd1};
    return {1'b0, p, t + 2'd1, 4'd0};
  endfunction

  always_comb begin
    sec_inc = inc_60(sec_q);
    min_inc = inc_60(min_q);
    hr_inc  = inc_hr(hr_q, pm_q);
    state_d = state_q;
    sec_d   = sec_q;
    min_d   = min_q;
    hr_d    = hr_q;
    pm_d    = pm_q;
    wrap_d  = 1'b0;
    case (state_q)
      RUN: begin
        if (set_en) begin
          state_d = SET;
          sec_d   = 7'd0;
        end else if (tick_1hz) begin
          sec_d = sec_inc[6:0];
          if (sec_inc[7]) begin
            min_d = min_inc[6:0];
            if (min_inc[7]) begin
              hr_d   = hr_inc[5:0];
              pm_d   = hr_inc[6];
              wrap_d = hr_inc[7];
            end
          end
        end
      end
      SET: begin
        if (!set_en) begin
          state_d = RUN;
        end else if (set_inc) begin
          case (set_sel)
            2'b00: sec_d = sec_inc[6:0];
            2'b01: min_d = min_inc[6:0];
            2'b10: begin
              hr_d = hr_inc[5:0];
              pm_d = hr_inc[6];
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      sec_q   <= 7'd0;
      min_q   <= 7'd0;
      hr_q    <= HOURS_24 ? 6'h00 : 6'h12;
      pm_q    <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hr_q    <= hr_d;
      pm_q    <= pm_d;
      wrap_q  <= wrap_d;
    end
  end

  assign hr_tens  = hr_q[5:4];
  assign hr_ones  = hr_q[3:0];
  assign min_tens = min_q[6:4];
  assign min_ones = min_q[3:0];
  assign sec_tens = sec_q[6:4];
  assign sec_ones = sec_q[3:0];
  assign pm       = pm_q;
  assign day_wrap = wrap_q;
  assign in_set   = (state_q == SET);

endmodule

// File: tb/tb_bcd_time_counter.sv
// Bench for bcd_time_counter: a 24h and a 12h instance share stimulus and are checked every
// cycle against a time-of-day model kept as plain hour/minute/second integers.
module tb_bcd_time_counter;

  logic       clk = 1'b0;
  logic       rst_n, tick_1hz, set_en, set_inc;
  logic [1:0] set_sel;

  logic [1:0] a_hr_tens, b_hr_tens;
  logic [3:0] a_hr_ones, b_hr_ones, a_min_ones, b_min_ones, a_sec_ones, b_sec_ones;
  logic [2:0] a_min_tens, b_min_tens, a_sec_tens, b_sec_tens;
  logic       a_pm, b_pm, a_day_wrap, b_day_wrap, a_in_set, b_in_set;

  int total = 0;
  int bad   = 0;

  // Reference model: hour of day 0..23 (shared by both displays), minute, second.
  int m_h, m_m, m_s;
  bit m_set, m_wrap;

  always #5 clk = ~clk;

  bcd_time_counter #(.HOURS_24(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .set_en(set_en), .set_sel(set_sel),
    .set_inc(set_inc), .hr_tens(a_hr_tens), .hr_ones(a_hr_ones), .min_tens(a_min_tens),
    .min_ones(a_min_ones), .sec_tens(a_sec_tens), .sec_ones(a_sec_ones), .pm(a_pm),
    .day_wrap(a_day_wrap), .in_set(a_in_set)
  );

  bcd_time_counter #(.HOURS_24(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .set_en(set_en), .set_sel(set_sel),
    .set_inc(set_inc), .hr_tens(b_hr_tens), .hr_ones(b_hr_ones), .min_tens(b_min_tens),
    .min_ones(b_min_ones), .sec_tens(b_sec_tens), .sec_ones(b_sec_ones), .pm(b_pm),
    .day_wrap(b_day_wrap), .in_set(b_in_set)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_time(input bit twelve);
    int hh;
    hh = m_h;
    if (twelve) hh = (m_h % 12 == 0) ? 12 : m_h % 12;
    return 32'({2'(hh / 10), 4'(hh % 10), 3'(m_m / 10), 4'(m_m % 10),
                3'(m_s / 10), 4'(m_s % 10)});
  endfunction

  task automatic model_step(input bit rn, input bit tk, input bit sen, input logic [1:0] sel,
                            input bit inc);
    int t;
    m_wrap = 1'b0;
    if (!rn) begin
      m_h = 0; m_m = 0; m_s = 0; m_set = 1'b0;
    end else if (!m_set) begin
      if (sen) begin
        m_set = 1'b1;
        m_s   = 0;
      end else if (tk) begin
        t = m_h * 3600 + m_m * 60 + m_s + 1;
        if (t == 86400) begin
          t = 0;
          m_wrap = 1'b1;
        end
        m_h = t / 3600;
        m_m = (t / 60) % 60;
        m_s = t % 60;
      end
    end else begin
      if (!sen) m_set = 1'b0;
      else if (inc) begin
        if (sel == 2'b00) m_s = (m_s + 1) % 60;
        if (sel == 2'b01) m_m = (m_m + 1) % 60;
        if (sel == 2'b10) m_h = (m_h + 1) % 24;
      end
    end
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, compare both instances.
  task automatic cycle(input bit rn, input bit tk, input bit sen, input logic [1:0] sel,
                       input bit inc);
    rst_n = rn; tick_1hz = tk; set_en = sen; set_sel = sel; set_inc = inc;
    @(posedge clk);
    #1;
    model_step(rn, tk, sen, sel, inc);
    check("time24", 32'({a_hr_tens, a_hr_ones, a_min_tens, a_min_ones, a_sec_tens, a_sec_ones}),
          exp_time(1'b0));
    check("pm24", 32'(a_pm), 32'd0);
    check("wrap24", 32'(a_day_wrap), 32'(m_wrap));
    check("inset24", 32'(a_in_set), 32'(m_set));
    check("time12", 32'({b_hr_tens, b_hr_ones, b_min_tens, b_min_ones, b_sec_tens, b_sec_ones}),
          exp_time(1'b1));
    check("pm12", 32'(b_pm), 32'(m_h >= 12));
    check("wrap12", 32'(b_day_wrap), 32'(m_wrap));
    check("inset12", 32'(b_in_set), 32'(m_set));
  endtask

  // Enter SET, bump each field up to the target (random ticks must be ignored), return to RUN.
  task automatic go_time(input int h, input int mi, input int s);
    int n;
    cycle(1'b1, 1'b0, 1'b1, 2'b11, 1'b0);
    n = (h - m_h + 24) % 24;
    repeat (n) cycle(1'b1, 1'($urandom_range(0, 1)), 1'b1, 2'b10, 1'b1);
    n = (mi - m_m + 60) % 60;
    repeat (n) cycle(1'b1, 1'($urandom_range(0, 1)), 1'b1, 2'b01, 1'b1);
    n = (s - m_s + 60) % 60;
    repeat (n) cycle(1'b1, 1'($urandom_range(0, 1)), 1'b1, 2'b00, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 2'b11, 1'b0);
  endtask

  initial begin
    bit sen_r;
    rst_n = 1'b0; tick_1hz = 1'b0; set_en = 1'b0; set_sel = 2'b00; set_inc = 1'b0;
    m_h = 0; m_m = 0; m_s = 0; m_set = 1'b0; m_wrap = 1'b0;

    // reset, including reset held against every other input
    cycle(1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 2'b10, 1'b1);

    // seconds into minutes
    go_time(0, 0, 58);
    cycle(1'b1, 1'b1, 1'b0, 2'b11, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 2'b11, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 2'b11, 1'b0);

    // full-day rollover, wrap pulse lasts one cycle
    go_time(23, 59, 59);
    cycle(1'b1, 1'b1, 1'b0, 2'b11, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 2'b11, 1'b0);

    // 12-hour boundaries: 11->12 AM/PM, 12->01 PM, 11 PM -> 12 AM
    go_time(11, 59, 59);
    cycle(1'b1, 1'b1, 1'b0, 2'b11, 1'b0);
    go_time(12, 59, 59);
    cycle(1'b1, 1'b1, 1'b0, 2'b11, 1'b0);
    go_time(23, 59, 59);
    cycle(1'b1, 1'b1, 1'b0, 2'b11, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 2'b11, 1'b0);

    // SET entry with a coincident tick, minute wrap without hour carry, frozen time
    go_time(10, 20, 33);
    cycle(1'b1, 1'b1, 1'b1, 2'b01, 1'b0);
    repeat (40) cycle(1'b1, 1'b0, 1'b1, 2'b01, 1'b1);
    repeat (3) cycle(1'b1, 1'b1, 1'b1, 2'b01, 1'b0);
    repeat (3) cycle(1'b1, 1'b0, 1'b1, 2'b11, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 2'b00, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 2'b00, 1'b0);

    // reset in the middle of SET
    cycle(1'b1, 1'b0, 1'b1, 2'b10, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 2'b10, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 2'b10, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 2'b10, 1'b0);

    // random traffic
    sen_r = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) sen_r = ~sen_r;
      cycle($urandom_range(0, 63) != 0, $urandom_range(0, 2) == 0, sen_r,
            2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
